// File: rtl/aes_encipher_block.sv
// aes_encipher_block
//   Iterative AES round datapath. Takes round keys from aes_key_gen by
//   driving a round index, and substitutes one 32-bit column per cycle
//   through an external sbox. One round = 4 SUB cycles + 1 MIX cycle.
//
//   Optional feature macro: AES_ENC_KEYLEN256_EN
//     defined   : keylen=1 selects Nr=14 (AES-256), keylen=0 selects Nr=10
//     undefined : keylen ignored, Nr fixed at 10
//
// Ports
//   aclk       in   1    clock, rising edge
//   aresetn    in   1    synchronous active-low reset
//   keylen     in   1    0=AES-128, 1=AES-256; sampled at accept
//   key_ready  in   1    key schedule valid; falling mid-run aborts
//   start      in   1    request, accepted when ready && key_ready
//   block      in   128  plaintext, sampled at accept
//   round      out  4    round index to aes_key_gen
//   round_key  in   128  round key for current round index
//   sbox_feed  out  32   column word to sbox (0 outside SUB)
//   new_sbox   in   32   substituted column from sbox
//   result     out  128  ciphertext, held until next accept
//   ready      out  1    idle and able to accept
//   valid      out  1    one-cycle pulse when result updates
module aes_encipher_block (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         keylen,
    input  logic         key_ready,
    input  logic         start,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sbox_feed,
    input  logic [31:0]  new_sbox,
    output logic [127:0] result,
    output logic         ready,
    output logic         valid
);

    typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

    state_t       state;
    logic [127:0] st;
    logic [1:0]   wc;
    logic [3:0]   rc;
    logic [127:0] sub_st;
    logic [127:0] shifted;
    logic [127:0] mix_out;
    logic         final_round;

`ifdef AES_ENC_KEYLEN256_EN
    logic [3:0] nr;
    assign final_round = (rc == nr);
`else
    logic unused_keylen;
    assign unused_keylen = keylen;
    assign final_round   = (rc == 4'd10);
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    // Byte i sits at bits 127-8i; row = i%4, column = i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++)
            o[127 - 32 * c -: 32] = mix_column(s[127 - 32 * c -: 32]);
        return o;
    endfunction

    // Column select for the sbox and write-back of its result.
    always_comb begin
        sub_st    = st;
        sbox_feed = '0;
        case (wc)
            2'd0: begin sub_st[127:96] = new_sbox; if (state == SUB) sbox_feed = st[127:96]; end
            2'd1: begin sub_st[95:64]  = new_sbox; if (state == SUB) sbox_feed = st[95:64];  end
            2'd2: begin sub_st[63:32]  = new_sbox; if (state == SUB) sbox_feed = st[63:32];  end
            default: begin sub_st[31:0] = new_sbox; if (state == SUB) sbox_feed = st[31:0]; end
        endcase
    end

    assign shifted = shift_rows(st);
    assign mix_out = (final_round ? shifted : mix_columns(shifted)) ^ round_key;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= IDLE;
            st     <= '0;
            wc     <= '0;
            rc     <= '0;
            round  <= '0;
            result <= '0;
            valid  <= 1'b0;
            ready  <= 1'b1;
`ifdef AES_ENC_KEYLEN256_EN
            nr     <= 4'd10;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    // ready is registered so it stays low through the valid cycle
                    ready <= 1'b1;
                    round <= '0;
                    if (start && ready && key_ready) begin
                        st    <= block ^ round_key;
                        rc    <= 4'd1;
                        round <= 4'd1;
                        wc    <= '0;
                        ready <= 1'b0;
                        state <= SUB;
`ifdef AES_ENC_KEYLEN256_EN
                        nr    <= keylen ? 4'd14 : 4'd10;
`endif
                    end
                end
                SUB: begin
                    if (!key_ready) begin
                        state <= IDLE;
                        round <= '0;
                        wc    <= '0;
                        ready <= 1'b1;
                    end else begin
                        st <= sub_st;
                        wc <= wc + 2'd1;
                        if (wc == 2'd3)
                            state <= MIX;
                    end
                end
                MIX: begin
                    if (!key_ready) begin
                        state <= IDLE;
                        round <= '0;
                        wc    <= '0;
                        ready <= 1'b1;
                    end else begin
                        st <= mix_out;
                        if (final_round) begin
                            result <= mix_out;
                            valid  <= 1'b1;
                            round  <= '0;
                            state  <= IDLE;
                        end else begin
                            rc    <= rc + 4'd1;
                            round <= rc + 4'd1;
                            wc    <= '0;
                            state <= SUB;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    round <= '0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_encipher_block.md
# aes_encipher_block

Round datapath that consumes the expanded key schedule produced by `aes_key_gen` and enciphers one 128-bit block per request.

- Drives the round index to `aes_key_gen` and samples the round key returned for that index.
- Performs SubBytes one 32-bit column at a time through its own `sbox` instance, on the same 32-bit feed/return port style as the key generator.
- Sits directly downstream of `aes_key_gen` and is the block that reports cipher results to the AES top level.

## Interface
Parameters:
- none

Ports:
- `aclk`  in  1  clock, all logic on rising edge
- `aresetn`  in  1  reset, synchronous, active-low
- `keylen`  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled at accept
- `key_ready`  in  1  key schedule valid, from `aes_key_gen`
- `start`  in  1  request; accepted only when `ready`=1 and `key_ready`=1
- `block`  in  128  plaintext, sampled at accept
- `round`  out  4  round index to `aes_key_gen`
- `round_key`  in  128  key for current `round`; combinationally valid while `round` is stable
- `sbox_feed`  out  32  column word to `sbox`
- `new_sbox`  in  32  substituted word from `sbox` (combinational)
- `result`  out  128  ciphertext; held until the next accept
- `ready`  out  1  idle, able to accept
- `valid`  out  1  one-cycle pulse when `result` is updated

## Operation
- State register `st[127:0]` (FIPS-197 byte order, column 0 in bits 127:96), word counter `wc[1:0]`, round counter `rc[3:0]`, latched `nr`.
- FSM states: IDLE, SUB, MIX.
- IDLE
  - `round`=0, `ready`=1.
  - On accept: `st <= block ^ round_key`, `nr` <= 10 or 14 from `keylen`, `rc`/`round` <= 1, `wc` <= 0, go to SUB.
- SUB
  - `sbox_feed` = `st` column `wc`; `new_sbox` is written back into column `wc`; `wc` increments.
  - After `wc`=3, go to MIX.
- MIX
  - `st <= MixColumns(ShiftRows(st)) ^ round_key`.
  - When `rc`=`nr`, MixColumns is skipped (final round), `result <= ` the new state, `valid` pulses, `round` <= 0, go to IDLE.
  - Otherwise `rc`/`round` increment, `wc` <= 0, go to SUB.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x1B; all byte arithmetic is 8-bit with no carry out.
- `sbox_feed` = 0 outside SUB.
- `start` with `ready`=0 or `key_ready`=0: ignored, not queued.
- `key_ready` falling while in SUB/MIX: abort to IDLE, `round`=0, no `valid`, `result` unchanged.
- Reset mid-operation: IDLE immediately, no `valid`.

## Timing
- Reset values:
  - `result`=0, `valid`=0, `ready`=1, `round`=0, `sbox_feed`=0.
  - Internal `st`, `wc`, `rc` = 0.
- Each round takes 5 cycles: 4 SUB + 1 MIX.
- `valid` is high in the cycle 5·Nr clocks after the accepting edge: 50 for AES-128, 70 for AES-256.
- `ready` is 0 from the cycle after accept through the `valid` cycle, and 1 the following cycle.
- Minimum interval between back-to-back accepts: 5·Nr+1 cycles.
- `round` changes only at the SUB entry edge of each round and is stable through that round's MIX. This guarantees `round_key` is settled when MIX samples it.
- `start` asserted in the same cycle as `valid` is not accepted (`ready`=0).

## Configuration
- `AES_ENC_KEYLEN256_EN` defined: `keylen`=1 selects Nr=14, and `round` reaches 14.
- `AES_ENC_KEYLEN256_EN` undefined: `keylen` is ignored, Nr is fixed at 10, and the Nr latch and 14-round compare logic are not built.

## Test plan
- AES-128 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, `block` 00112233445566778899aabbccddeeff, `start` pulse.
  - Response: `valid` 50 cycles after accept, `result` 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256 vector (`AES_ENC_KEYLEN256_EN` defined):
  - Stimulus: key 000102…1e1f, `keylen`=1, same `block`.
  - Response: `valid` after 70 cycles, `result` 8ea2b7ca516745bfeafc49904b496089.
- Gating:
  - Stimulus: `start` held high with `key_ready`=0 for 20 cycles, then `key_ready`=1.
  - Response: no accept until `key_ready`=1, exactly one accept, one `valid`.
- Busy:
  - Stimulus: second `start` 10 cycles after an accept.
  - Response: ignored; one `valid`; `ready` returns to 1 the cycle after `valid`.
- Reset mid-operation:
  - Stimulus: `aresetn`=0 for one cycle during round 5.
  - Response: `ready`=1, `round`=0, `result`=0, no `valid`; a following AES-128 vector still passes.
- Round sequence:
  - Check: monitor `round` during an AES-128 run.
  - Required: `round` steps 1..10, each value held for 5 cycles, then returns to 0.
